// File: rtl/local_history_table.sv
// -----------------------------------------------------------------------------
// local_history_table
//
// Local history table (LHT) for the tournament branch predictor. Each of
// ENTRIES = 2**INDEX_W entries holds a HIST_W-bit taken/not-taken shift
// register. An entry is selected by idx = pc[INDEX_W+1:2]. Bits pc[1:0] and the
// bits above the index are ignored, so aliasing PCs share an entry.
//
// Parameters:
//   PC_W     width of the PC inputs (must be at least INDEX_W+3)
//   INDEX_W  index bits; ENTRIES = 2**INDEX_W
//   HIST_W   history bits per entry, legal range 2..16
//
// Ports:
//   clock           system clock; all state changes on posedge
//   reset           synchronous, active-low reset. It clears every entry and
//                   the read port, and it drops any request in that cycle.
//   lookup_valid    lookup request this cycle
//   lookup_pc       PC of the branch being predicted
//   rd_valid        registered lookup_valid (1-cycle latency)
//   rd_history      registered history of the looked-up entry. It holds its
//                   value in cycles with no lookup.
//   upd_valid       commit-time outcome update
//   upd_pc          PC of the resolved branch
//   upd_taken       resolved direction, 1 = taken. It shifts into the LSB.
//   repair_valid    overwrite an entry (mispredict recovery)
//   repair_pc       PC of the entry to repair
//   repair_history  corrected history value
//
// Write rules: if a repair and an update hit the same entry in one cycle, the
// repair wins and the update is dropped. If they hit different entries, both
// are applied.
//
// Optional feature (macro LHT_BYPASS_EN):
//   Defined     a lookup that hits the index being written in the same cycle
//               returns the post-write value. The repair value has priority
//               over the shifted update value.
//   Undefined   the lookup returns the table contents from before that
//               cycle's write, and no forwarding logic is built.
// -----------------------------------------------------------------------------
module local_history_table #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INDEX_W = 10,
    parameter int unsigned HIST_W  = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              rd_valid,
    output logic [HIST_W-1:0] rd_history,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic              repair_valid,
    input  logic [PC_W-1:0]   repair_pc,
    input  logic [HIST_W-1:0] repair_history
);

    localparam int unsigned ENTRIES = 2 ** INDEX_W;

    // -------------------------------------------------------------------------
    // Index extraction
    // -------------------------------------------------------------------------
    logic [INDEX_W-1:0] lookup_idx;
    logic [INDEX_W-1:0] upd_idx;
    logic [INDEX_W-1:0] repair_idx;

    assign lookup_idx = lookup_pc[INDEX_W+1:2];
    assign upd_idx    = upd_pc[INDEX_W+1:2];
    assign repair_idx = repair_pc[INDEX_W+1:2];

    // The byte-offset bits and the bits above the index do not take part in
    // indexing. They are folded here so that it is explicit that they are
    // unused.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[PC_W-1:INDEX_W+2], lookup_pc[1:0],
                              upd_pc[PC_W-1:INDEX_W+2],    upd_pc[1:0],
                              repair_pc[PC_W-1:INDEX_W+2], repair_pc[1:0]};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [HIST_W-1:0] table_q [ENTRIES];
    logic [HIST_W-1:0] table_d [ENTRIES];

    logic              rd_valid_q;
    logic              rd_valid_d;
    logic [HIST_W-1:0] rd_history_q;
    logic [HIST_W-1:0] rd_history_d;

    // -------------------------------------------------------------------------
    // Write path
    // -------------------------------------------------------------------------
    // The newest outcome enters at the LSB. The oldest bit falls off the MSB.
    logic [HIST_W-1:0] upd_shifted;
    assign upd_shifted = {table_q[upd_idx][HIST_W-2:0], upd_taken};

    always_comb begin
        table_d = table_q;
        if (upd_valid) begin
            table_d[upd_idx] = upd_shifted;
        end
        // The repair is applied last, so it overrides an update to the same
        // entry.
        if (repair_valid) begin
            table_d[repair_idx] = repair_history;
        end
    end

    // -------------------------------------------------------------------------
    // Read path
    // -------------------------------------------------------------------------
    logic [HIST_W-1:0] rd_value;

`ifdef LHT_BYPASS_EN
    // Forward the value being written this cycle. Repair takes priority, which
    // mirrors the write-path ordering above.
    always_comb begin
        rd_value = table_q[lookup_idx];
        if (repair_valid && (repair_idx == lookup_idx)) begin
            rd_value = repair_history;
        end else if (upd_valid && (upd_idx == lookup_idx)) begin
            rd_value = upd_shifted;
        end
    end
`else
    assign rd_value = table_q[lookup_idx];
`endif

    always_comb begin
        rd_valid_d   = lookup_valid;
        rd_history_d = rd_history_q;
        if (lookup_valid) begin
            rd_history_d = rd_value;
        end
    end

    // -------------------------------------------------------------------------
    // Registers (synchronous active-low reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_valid_q   <= 1'b0;
            rd_history_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            rd_valid_q   <= rd_valid_d;
            rd_history_q <= rd_history_d;
            table_q      <= table_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_history = rd_history_q;

endmodule

// File: doc/local_history_table.md
Name: local_history_table

Overview:
- Parametrised, multi-entry local history table (LHT) for the tournament branch predictor.
- Holds one HIST_W-bit taken/not-taken shift register per entry, indexed by PC bits.
- Supports three operations: a registered lookup port for the local predictor, a commit-time update port, and a mispredict repair port that overwrites an entry.
- Generalises the single-register LHT to ENTRIES x HIST_W.

Parameters:
PC_W, 32, width of the PC inputs
INDEX_W, 10, index bits; ENTRIES = 2**INDEX_W (localparam); index = pc[INDEX_W+1:2]
HIST_W, 10, history bits per entry; legal range 2..16

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-low reset; sampled on posedge clock
lookup_valid  input  1  lookup request this cycle
lookup_pc  input  PC_W  PC of branch being predicted
rd_valid  output  1  lookup result valid (registered)
rd_history  output  HIST_W  history of looked-up entry (registered)
upd_valid  input  1  commit-time outcome update
upd_pc  input  PC_W  PC of resolved branch
upd_taken  input  1  resolved direction, 1 = taken
repair_valid  input  1  overwrite entry (mispredict recovery)
repair_pc  input  PC_W  PC of entry to repair
repair_history  input  HIST_W  corrected history value

Behaviour:
- Reset (reset==0 at posedge):
  - All ENTRIES cleared to 0.
  - rd_valid <= 0, rd_history <= 0.
  - Update and repair requests in that cycle are ignored.
  - A lookup issued in the reset cycle is dropped: rd_valid is 0 in the following cycle.
- Indexing:
  - idx = pc[INDEX_W+1:2]; pc[1:0] and upper bits are ignored.
  - Aliasing PCs share an entry.
- Lookup:
  - Latency 1 cycle. rd_valid = lookup_valid registered; rd_history = table[idx] registered.
  - When lookup_valid is 0: rd_valid <= 0 and rd_history holds its previous value.
- Update (upd_valid==1):
  - table[idx] <= {table[idx][HIST_W-2:0], upd_taken}; newest outcome in LSB.
  - Oldest bit discarded; no saturation.
- Repair (repair_valid==1):
  - table[idx] <= repair_history.
- Repair and update in the same cycle:
  - Different idx: both applied.
  - Same idx: repair wins and the update is dropped.
- Lookup and write to the same idx in the same cycle:
  - Returns the pre-write value, unless LHT_BYPASS_EN is defined (see below).
- No back-pressure: every port accepts a request every cycle; there is no busy/ready.
- Entries not addressed in a cycle hold their value.

Optional Feature:
- Macro: LHT_BYPASS_EN.
- Defined: write-to-read forwarding. If a lookup matches the idx of an update or repair in the same cycle, rd_history next cycle equals the post-write value (repair value if repair matches, else shifted value). This costs one comparator and mux pair per write port.
- Not defined: rd_history returns the table contents before that cycle's write; no forwarding logic is synthesised.

Test Plan:
1. Reset: hold reset=0 for 3 cycles, then lookup pc 0x0, 0x100, 0xFFC → rd_valid=1 one cycle after each lookup, rd_history=0; rd_valid=0 in cycles with no lookup.
2. Shift sequence at pc 0x100 (HIST_W=10):
   - Updates 0,1,1 → lookup returns 0000000011.
   - Then 8 updates of 0 → 1100000000.
   - Then 4 updates of 1 → 0000001111.
   - Any other index still reads 0.
3. Aliasing: update taken=1 at pc 0x100, then lookup pc 0x1100 (same idx 0x040) → 0000000001; lookup pc 0x104 → 0.
4. Simultaneous repair and update, both pc 0x200: repair_history=1010101010, upd_taken=1 → entry reads 1010101010. Repair pc 0x200 with update pc 0x204 → both entries written.
5. Same-cycle lookup and update, pc 0x300 holding 0000000001, upd_taken=1:
   - Without LHT_BYPASS_EN → rd_history=0000000001.
   - With LHT_BYPASS_EN → 0000000011.
   - In both builds a lookup on the next cycle returns 0000000011.
6. Reset mid-operation: fill several entries, assert reset=0 in the same cycle as a lookup and an update → next cycle rd_valid=0; all subsequent lookups return 0.
